// File: rtl/set_time_pkg.sv
// set_time_pkg: shared state, error codes and default field limits for the time-setting port
package set_time_pkg;
  typedef enum logic {IDLE, WAIT_ACK} state_t;
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_SEL   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;
  localparam logic [20:0] DEF_LIMITS = {7'd23, 7'd59, 7'd59};
endpackage

// File: rtl/sync_rise.sv
// sync_rise: multi-flop synchroniser for an asynchronous level with a one-cycle rise pulse
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] s;
  logic last;
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      last <= 1'b0;
    end else begin
      s <= STAGES'({s, d});
      last <= s[STAGES-1];
    end
  end
  assign rise = s[STAGES-1] & ~last;
endmodule

// File: rtl/set_time_ctrl.sv
// set_time_ctrl: captures a range-checked field write on a button rise and hands it to the counter bank
module set_time_ctrl
  import set_time_pkg::*;
#(
  parameter int FIELDS = 3,
  parameter int DW = 7,
  parameter int SELW = (FIELDS > 1) ? $clog2(FIELDS) : 1,
  parameter logic [FIELDS*DW-1:0] LIMITS = DEF_LIMITS,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            en_set,
  input  logic            submit,
  input  logic [SELW-1:0] select,
  input  logic [DW-1:0]   din,
  output logic            wr_valid,
  input  logic            wr_ack,
  output logic [DW-1:0]   dout,
  output logic [SELW-1:0] selout,
  output logic            err,
  output logic [1:0]      err_code,
  output logic            busy
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  state_t state;
  logic rise;
  logic bad_sel;
  logic [DW-1:0] lim;
  logic [CW-1:0] cnt;
  sync_rise #(.STAGES(2)) u_sync (.clk(clk), .rst(rst), .d(submit), .rise(rise));
  always_comb begin
    lim = '0;
    for (int i = 0; i < FIELDS; i++) lim = (select == SELW'(i)) ? LIMITS[i*DW +: DW] : lim;
  end
  assign bad_sel = 32'(select) >= FIELDS;
  // cnt counts completed WAIT_ACK cycles; hitting TLAST means wr_valid has been up TIMEOUT cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_valid <= 1'b0;
      dout <= '0;
      selout <= '0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      busy <= 1'b0;
      cnt <= '0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (rise && en && en_set) begin
          if (bad_sel) begin
            err <= 1'b1;
            err_code <= ERR_SEL;
          end else if (din > lim) begin
            err <= 1'b1;
            err_code <= ERR_RANGE;
          end else begin
            dout <= din;
            selout <= select;
            wr_valid <= 1'b1;
            busy <= 1'b1;
            cnt <= '0;
            state <= WAIT_ACK;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (wr_ack || !en || !en_set || (TIMEOUT != 0 && cnt == TLAST)) begin
          state <= IDLE;
          wr_valid <= 1'b0;
          busy <= 1'b0;
          dout <= '0;
          selout <= '0;
          if (!wr_ack && en && en_set) begin
            err <= 1'b1;
            err_code <= ERR_TMO;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_set_time_ctrl.sv
// tb_set_time_ctrl: directed and randomized checks of set_time_ctrl against a transaction-level model
module tb_set_time_ctrl;
  localparam int T = 4;
  logic clk = 0;
  logic rst, en, en_set, submit, wr_valid, err, busy;
  logic wr_ack = 0;
  logic [1:0] select, selout, err_code;
  logic [6:0] din, dout;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;
  int ack_dly = -1, vcnt = 0;
  bit ack_rand = 0;
  int nwr = 0, vhigh = 0, nerr = 0;
  logic [6:0] cap_dout = 0;
  logic [1:0] cap_sel = 0;
  bit prev_v = 0;
  bit h1, h2, h3, m_rise, m_busy, m_err;
  logic [6:0] m_dout;
  logic [1:0] m_sel, m_code;
  int m_age;
  int lim[3] = '{59, 59, 23};

  always #5 clk = ~clk;

  set_time_ctrl #(.FIELDS(3), .DW(7), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .en(en), .en_set(en_set), .submit(submit),
    .select(select), .din(din), .wr_valid(wr_valid), .wr_ack(wr_ack),
    .dout(dout), .selout(selout), .err(err), .err_code(err_code), .busy(busy)
  );

  // Model: a rise is seen two edges after submit is first sampled high; a write lives until ack, abort or T cycles
  always @(posedge clk) begin
    if (rst) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_busy = 0; m_err = 0; m_dout = 0; m_sel = 0; m_code = 0; m_age = 0;
    end else begin
      m_rise = h2 && !h3;
      m_err = 0;
      if (!m_busy) begin
        if (m_rise && en && en_set) begin
          if (select >= 3) begin m_err = 1; m_code = 2; end
          else if (int'(din) > lim[select]) begin m_err = 1; m_code = 1; end
          else begin m_busy = 1; m_dout = din; m_sel = select; m_age = 0; end
        end
      end else begin
        m_age++;
        if (wr_ack || !en || !en_set || m_age == T) begin
          if (!wr_ack && en && en_set) begin m_err = 1; m_code = 3; end
          m_busy = 0; m_dout = 0; m_sel = 0;
        end
      end
      h3 = h2; h2 = h1; h1 = submit;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_chk++;
      if ({wr_valid, busy, dout, selout, err, err_code} !== {m_busy, m_busy, m_dout, m_sel, m_err, m_code}) begin
        n_fail++;
        $display("FAIL model t=%0t valid/busy/dout/sel/err/code got %b/%b/%0d/%0d/%b/%0d expected %b/%b/%0d/%0d/%b/%0d",
                 $time, wr_valid, busy, dout, selout, err, err_code, m_busy, m_busy, m_dout, m_sel, m_err, m_code);
      end
    end
    if (wr_valid && !prev_v) nwr++;
    if (wr_valid) begin vhigh++; cap_dout = dout; cap_sel = selout; end
    if (err) nerr++;
    prev_v = wr_valid;
  end

  always @(negedge clk) begin
    vcnt = wr_valid ? vcnt + 1 : 0;
    wr_ack = wr_valid && (ack_rand ? ($urandom_range(0, 3) == 0) : (ack_dly >= 0 && vcnt > ack_dly));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr;
    nwr = 0; vhigh = 0; nerr = 0;
  endtask

  task automatic press(input logic [1:0] s, input logic [6:0] d);
    select = s; din = d; submit = 1;
    settle(3);
    submit = 0;
  endtask

  initial begin
    int b;
    rst = 1; en = 0; en_set = 0; submit = 0; select = 0; din = 0;
    settle(3);
    check("rst_valid", wr_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_code", err_code, 0);
    check("rst_busy", busy, 0);
    rst = 0; chk_on = 1; en = 1; en_set = 1;
    settle(2);
    ack_dly = 2; clr; press(1, 45); settle(8);
    check("wr_count", nwr, 1); check("wr_cycles", vhigh, 3);
    check("wr_dout", cap_dout, 45); check("wr_sel", cap_sel, 1); check("wr_err", nerr, 0);
    clr; press(2, 24); settle(6);
    check("rng_wr", nwr, 0); check("rng_err", nerr, 1); check("rng_code", err_code, 1);
    clr; press(2, 23); settle(8);
    check("lim_wr", nwr, 1); check("lim_dout", cap_dout, 23); check("lim_code", err_code, 1);
    clr; press(3, 5); settle(6);
    check("sel_wr", nwr, 0); check("sel_err", nerr, 1); check("sel_code", err_code, 2);
    ack_dly = -1; clr; press(0, 10); settle(10);
    check("tmo_cycles", vhigh, T); check("tmo_err", nerr, 1); check("tmo_code", err_code, 3);
    ack_dly = 0; clr; press(0, 59); settle(6);
    check("after_tmo_wr", nwr, 1); check("after_tmo_cycles", vhigh, 1); check("after_tmo_err", nerr, 0);
    en_set = 0; clr; press(1, 1); settle(6);
    check("drop_wr", nwr, 0); check("drop_err", nerr, 0);
    en_set = 1; settle(2);
    ack_dly = 1; clr; select = 1; din = 30; submit = 1; settle(20); submit = 0; settle(6);
    check("held_wr", nwr, 1);
    ack_dly = 3; clr; press(1, 5); settle(1); submit = 1; settle(3); submit = 0; settle(8);
    check("extra_wr", nwr, 1); check("extra_cycles", vhigh, 4); check("extra_err", nerr, 0);
    ack_dly = -1; press(1, 7); rst = 1; settle(1);
    check("mid_rst_valid", wr_valid, 0); check("mid_rst_dout", dout, 0);
    check("mid_rst_busy", busy, 0); check("mid_rst_code", err_code, 0);
    rst = 0; settle(2);
    clr; press(1, 7); en = 0; settle(1);
    check("abort_valid", wr_valid, 0);
    en = 1; settle(6);
    check("abort_err", nerr, 0);
    ack_rand = 1;
    repeat (3000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 19) != 0);
      en_set = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 2) == 0) submit = ~submit;
      select = 2'($urandom_range(0, 3));
      b = (select == 2) ? 23 : 59;
      din = $urandom_range(0, 1) ? 7'($urandom_range(0, 127)) : 7'(b - 1 + int'($urandom_range(0, 2)));
    end
    rst = 0; submit = 0;
    settle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/set_time_ctrl.md
# set_time_ctrl

Parametrised, fully synchronous successor of the clock-setting write port. Captures a user-entered value and field select on a rising edge of the `submit` button and range-checks the value against a per-field limit. It then presents the value to the timekeeping counter bank with a valid/ack handshake, adding time-out and error reporting. It sits between the button/switch front end and the hour/minute/second (or wider) counter registers.

## Interface
- `FIELDS`, 3: number of settable fields (field 0 = seconds, 1 = minutes, 2 = hours by default).
- `DW`, 7: data width of each field value.
- `SELW`, `$clog2(FIELDS)` (min 1): width of the field select.
- `LIMITS`, `{7'd23, 7'd59, 7'd59}`: packed `FIELDS*DW` vector; slice i is the maximum legal value of field i.
- `TIMEOUT`, 255: ack wait limit in cycles; 0 disables the time-out.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  block enable.
- `en_set`  in  1  set mode active.
- `submit`  in  1  asynchronous button level.
- `select`  in  SELW  target field.
- `din`  in  DW  value to write.
- `wr_valid`  out  1  write request to counter bank.
- `wr_ack`  in  1  counter bank accepted the write.
- `dout`  out  DW  captured value; valid while `wr_valid`.
- `selout`  out  SELW  captured field; valid while `wr_valid`.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  last error: 00 none, 01 range, 10 bad select, 11 time-out.
- `busy`  out  1  high while in WAIT_ACK.

## Operation
- `submit` passes through a 2-flop synchroniser. A rise pulse is generated when the synchronised level goes from 0 to 1.
- States: IDLE, WAIT_ACK.
- **IDLE**, when the rise pulse is high and `en & en_set`:
  - If `select >= FIELDS`: pulse `err`, set `err_code=10`, stay in IDLE.
  - Else if `din > LIMITS[select]`: pulse `err`, set `err_code=01`, stay in IDLE.
  - Otherwise: register `din` to `dout` and `select` to `selout`, set `wr_valid=1`, clear the time-out counter, and go to WAIT_ACK.
- A rise pulse while `en & en_set` is low is discarded; no error is reported.
- **WAIT_ACK**:
  - `dout` and `selout` hold stable; `busy=1`; further rise pulses are dropped.
  - `wr_ack=1` → `wr_valid=0`, go to IDLE.
  - `en` or `en_set` low → abort: `wr_valid=0`, go to IDLE, no error.
  - Time-out counter reaches `TIMEOUT` (when `TIMEOUT != 0`) → `wr_valid=0`, pulse `err`, set `err_code=11`, go to IDLE.
- Priority within WAIT_ACK: ack, then abort, then time-out.
- `err_code` holds its value until the next error or reset. A successful write does not clear it.
- Idle outputs: `dout=0`, `selout=0`. No tri-state outputs.
- Range compare is unsigned, `DW` bits wide.

## Timing
- Reset values: `wr_valid=0`, `dout=0`, `selout=0`, `err=0`, `err_code=00`, `busy=0`, state IDLE, synchroniser flops 0.
- Latency: if `submit` is sampled high at edges k, k+1 and k+2, then `wr_valid` (or the `err` pulse) is high after edge k+2.
- An ack sampled at the first edge where `wr_valid` is seen high drops `wr_valid` after that edge. The minimum write is 1 cycle.
- Time-out: `wr_valid` stays high for exactly `TIMEOUT` cycles without ack, then drops. `err` is high for the following cycle.
- `rst` mid-transaction forces all reset values on the next edge; the pending write is lost.
- Holding `submit` high produces one write only; a new write needs a low→high transition.

## Structure
- `set_time_pkg`: state enum, `ERR_NONE/ERR_RANGE/ERR_SEL/ERR_TMO` constants, default `LIMITS` constant.
- Sub-module `sync_rise`: 2-flop synchroniser plus rise detect, parametrised on stage count (default 2). Reused for other buttons.
- Top level: FSM, capture registers, limit mux, time-out counter (`$clog2(TIMEOUT+1)` bits).

## Test plan
- **Valid write:** `en=en_set=1`, `select=1`, `din=45`, `submit` pulse, `wr_ack` 2 cycles after `wr_valid` → `dout=45`, `selout=1`, `wr_valid` high 3 cycles, `err=0`.
- **Range error:** `select=2`, `din=24` → no `wr_valid`, one `err` pulse, `err_code=01`. Then `din=23` → write succeeds and `err_code` stays 01.
- **Bad select:** `FIELDS=3`, `select=3` → `err_code=10`, no write.
- **Time-out:** `TIMEOUT=4`, no ack → `wr_valid` high 4 cycles, `err_code=11`. A second submit afterwards works normally.
- **Drops and held button:** `en_set` low at submit → nothing happens. `submit` held high 20 cycles → exactly one write. Extra submit in WAIT_ACK → ignored.
- **Reset and abort:** `rst` asserted in WAIT_ACK → all outputs reset next edge. `en` dropped in WAIT_ACK → `wr_valid` low, no `err`.
